// File: rtl/vscale_dbus_router_pkg.sv
// Shared types and constants for the vscale data-bus router.
// State encodings, transfer-size codes and lane count.
package vscale_dbus_router_pkg;

  localparam int HASTI_SIZE_WIDTH = 3;
  localparam int DBUS_LANES = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ERR  = 2'd2
  } dbus_state_e;

  localparam logic [HASTI_SIZE_WIDTH-1:0] SZ_BYTE = 3'd0;
  localparam logic [HASTI_SIZE_WIDTH-1:0] SZ_HALF = 3'd1;
  localparam logic [HASTI_SIZE_WIDTH-1:0] SZ_WORD = 3'd2;

endpackage

// File: rtl/vscale_dbus_decoder.sv
// Address window decode, alignment check and byte-lane strobes.
// Purely combinational; lowest matching window wins.
module vscale_dbus_decoder
  import vscale_dbus_router_pkg::*;
#(
  parameter int N_SLV = 4,
  parameter int ADDR_W = 32,
  parameter logic [N_SLV*ADDR_W-1:0] REGION_BASE = '0,
  parameter logic [N_SLV*ADDR_W-1:0] REGION_MASK = '0
) (
  input  logic [ADDR_W-1:0]           addr,
  input  logic [HASTI_SIZE_WIDTH-1:0] size,
  output logic [N_SLV-1:0]            hit,
  output logic                        unmapped,
  output logic                        misaligned,
  output logic [DBUS_LANES-1:0]       strb
);

  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] mask;

  always_comb begin
    hit = '0;
    base = '0;
    mask = '0;
    for (int i = N_SLV - 1; i >= 0; i--) begin
      base = REGION_BASE[i*ADDR_W +: ADDR_W];
      mask = REGION_MASK[i*ADDR_W +: ADDR_W];
      if ((addr & mask) == base) begin
        hit = '0;
        hit[i] = 1'b1;
      end
    end
  end

  assign unmapped = ~|hit;

  // unknown size codes are treated as misaligned so they error out
  always_comb begin
    misaligned = 1'b1;
    strb = '0;
    case (size)
      SZ_BYTE: begin
        misaligned = 1'b0;
        strb = 4'b0001 << addr[1:0];
      end
      SZ_HALF: begin
        misaligned = addr[0];
        strb = 4'b0011 << {addr[1], 1'b0};
      end
      SZ_WORD: begin
        misaligned = |addr[1:0];
        strb = 4'hF;
      end
      default: begin
        misaligned = 1'b1;
        strb = '0;
      end
    endcase
  end

endmodule

// File: rtl/vscale_dbus_router.sv
// Data-side router from the vscale dmem port to N slaves,
// with back-pressure, error completion and wait-state timeout.
module vscale_dbus_router
  import vscale_dbus_router_pkg::*;
#(
  parameter int N_SLV = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int IDX_W = 14,
  parameter logic [N_SLV*ADDR_W-1:0] REGION_BASE = '0,
  parameter logic [N_SLV*ADDR_W-1:0] REGION_MASK = '0,
  parameter int TIMEOUT = 16
) (
  input  logic                        clk_i,
  input  logic                        reset,
  input  logic                        dmem_en,
  input  logic                        dmem_wen,
  input  logic [HASTI_SIZE_WIDTH-1:0] dmem_size,
  input  logic [ADDR_W-1:0]           dmem_addr,
  input  logic [DATA_W-1:0]           dmem_wdata_delayed,
  output logic [DATA_W-1:0]           dmem_rdata,
  output logic                        dmem_stall,
  output logic                        dmem_err,
  output logic [N_SLV-1:0]            s_ren,
  output logic [IDX_W-1:0]            s_raddr,
  output logic [N_SLV-1:0]            s_wen,
  output logic [IDX_W-1:0]            s_waddr,
  output logic [DATA_W-1:0]           s_wdata,
  output logic [DBUS_LANES-1:0]       s_wstrb,
  input  logic [N_SLV*DATA_W-1:0]     s_rdata,
  input  logic [N_SLV-1:0]            s_ready
);

  localparam int CNT_W =
    (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  dbus_state_e state_q, state_d;

  logic [N_SLV-1:0]      sel_q;
  logic                  wen_q;
  logic [DBUS_LANES-1:0] strb_q;
  logic [IDX_W-1:0]      waddr_q;
  logic [CNT_W-1:0]      wait_q;

  logic [N_SLV-1:0]      hit;
  logic                  unmapped;
  logic                  misaligned;
  logic [DBUS_LANES-1:0] strb;

  logic busy, rdy, abort, stall;
  logic accept, bad, go;

  vscale_dbus_decoder #(
    .N_SLV      (N_SLV),
    .ADDR_W     (ADDR_W),
    .REGION_BASE(REGION_BASE),
    .REGION_MASK(REGION_MASK)
  ) u_dec (
    .addr      (dmem_addr),
    .size      (dmem_size),
    .hit       (hit),
    .unmapped  (unmapped),
    .misaligned(misaligned),
    .strb      (strb)
  );

  // data-phase qualifiers are forced off while reset is held
  assign busy  = (state_q == ST_BUSY) & ~reset;
  assign rdy   = |(s_ready & sel_q);
  assign abort = busy & ~rdy & (TIMEOUT != 0) &
                 (wait_q == CNT_W'(TIMEOUT));
  assign stall = busy & ~rdy & ~abort;

  assign bad    = unmapped | misaligned;
  assign accept = dmem_en & ~stall & ~reset;
  assign go     = accept & ~bad;

  always_ff @(posedge clk_i) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!stall) begin
      if (!accept)  state_d = ST_IDLE;
      else if (bad) state_d = ST_ERR;
      else          state_d = ST_BUSY;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset) begin
      sel_q   <= '0;
      wen_q   <= 1'b0;
      strb_q  <= '0;
      waddr_q <= '0;
    end else if (!stall) begin
      sel_q   <= go ? hit : '0;
      wen_q   <= go & dmem_wen;
      strb_q  <= (go & dmem_wen) ? strb : '0;
      waddr_q <= (go & dmem_wen) ?
                 dmem_addr[IDX_W+1:2] : '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset)
      wait_q <= '0;
    else if (stall && TIMEOUT != 0)
      wait_q <= wait_q + CNT_W'(1);
    else
      wait_q <= '0;
  end

  always_comb begin
    s_ren      = (go & ~dmem_wen) ? hit : '0;
    s_raddr    = dmem_addr[IDX_W+1:2];
    s_wen      = (busy & wen_q & ~abort) ? sel_q : '0;
    s_waddr    = waddr_q;
    s_wstrb    = strb_q;
    s_wdata    = dmem_wdata_delayed;
    dmem_stall = stall;
    dmem_err   = ((state_q == ST_ERR) & ~reset) | abort;
    dmem_rdata = '0;
    if (busy & rdy & ~wen_q) begin
      for (int i = 0; i < N_SLV; i++)
        if (sel_q[i])
          dmem_rdata = dmem_rdata |
                       s_rdata[i*DATA_W +: DATA_W];
    end
  end

endmodule

// File: tb/tb_vscale_dbus_router.sv
// Scoreboard bench for vscale_dbus_router: two windows,
// programmable slave wait states, TIMEOUT of 4.
module tb_vscale_dbus_router;

  localparam int TO = 4;

  logic        clk_i = 1'b0;
  logic        reset;
  logic        dmem_en;
  logic        dmem_wen;
  logic [2:0]  dmem_size;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata_delayed;
  logic [31:0] dmem_rdata;
  logic        dmem_stall;
  logic        dmem_err;
  logic [1:0]  s_ren;
  logic [13:0] s_raddr;
  logic [1:0]  s_wen;
  logic [13:0] s_waddr;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic [63:0] s_rdata;
  logic [1:0]  s_ready;
  logic [31:0] lat0, lat1;

  typedef struct {
    logic [1:0]  ren;
    logic [1:0]  sel;
    bit          wr;
    bit          err;
    logic [31:0] rdata;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [13:0] waddr;
    int          delay;
    int          stalls;
  } exp_t;

  exp_t q[$];
  int n_tests = 0;
  int n_fail = 0;

  vscale_dbus_router #(
    .N_SLV      (2),
    .ADDR_W     (32),
    .DATA_W     (32),
    .IDX_W      (14),
    .REGION_BASE({32'h2000_0000, 32'h0010_0000}),
    .REGION_MASK({32'hFFF0_0000, 32'hFFF0_0000}),
    .TIMEOUT    (TO)
  ) dut (
    .clk_i             (clk_i),
    .reset             (reset),
    .dmem_en           (dmem_en),
    .dmem_wen          (dmem_wen),
    .dmem_size         (dmem_size),
    .dmem_addr         (dmem_addr),
    .dmem_wdata_delayed(dmem_wdata_delayed),
    .dmem_rdata        (dmem_rdata),
    .dmem_stall        (dmem_stall),
    .dmem_err          (dmem_err),
    .s_ren             (s_ren),
    .s_raddr           (s_raddr),
    .s_wen             (s_wen),
    .s_waddr           (s_waddr),
    .s_wdata           (s_wdata),
    .s_wstrb           (s_wstrb),
    .s_rdata           (s_rdata),
    .s_ready           (s_ready)
  );

  always #5 clk_i = ~clk_i;

  // slaves latch a word tagged with their identity
  assign s_rdata = {lat1, lat0};
  always @(posedge clk_i) begin
    if (s_ren[0]) lat0 <= 32'hD000_0000 ^ {18'd0, s_raddr};
    if (s_ren[1]) lat1 <= 32'h5E60_0000 ^ {18'd0, s_raddr};
  end

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(bit wen, logic [2:0] size,
                                 logic [31:0] a,
                                 logic [31:0] wd, int delay);
    exp_t e;
    bit mis, bad;
    logic [1:0] sel;
    if ((a & 32'hFFF0_0000) == 32'h0010_0000) sel = 2'b01;
    else if ((a & 32'hFFF0_0000) == 32'h2000_0000) sel = 2'b10;
    else sel = 2'b00;
    case (size)
      3'd0: mis = 1'b0;
      3'd1: mis = a[0];
      3'd2: mis = (a[1:0] != 2'b00);
      default: mis = 1'b1;
    endcase
    bad = (sel == 2'b00) || mis;
    e.ren = (!bad && !wen) ? sel : 2'b00;
    e.sel = bad ? 2'b00 : sel;
    e.wr = wen && !bad;
    e.wdata = wd;
    e.delay = delay;
    e.stalls = bad ? 0 : ((delay > TO) ? TO : delay);
    e.err = bad || (delay > TO);
    e.rdata = 32'h0;
    if (!e.wr && !e.err)
      e.rdata = (sel == 2'b01 ? 32'hD000_0000 : 32'h5E60_0000)
                ^ {18'd0, a[15:2]};
    e.strb = 4'h0;
    if (e.wr)
      case (size)
        3'd0: e.strb = 4'b0001 << a[1:0];
        3'd1: e.strb = a[1] ? 4'b1100 : 4'b0011;
        default: e.strb = 4'hF;
      endcase
    e.waddr = e.wr ? a[15:2] : 14'd0;
    return e;
  endfunction

  task automatic step(bit en, bit wen, logic [2:0] size,
                      logic [31:0] a, logic [31:0] wd,
                      int delay);
    exp_t e, n;
    int k;
    @(posedge clk_i); #1;
    dmem_en = en;
    dmem_wen = wen;
    dmem_size = size;
    dmem_addr = a;
    s_ready = 2'b11;
    if (q.size() > 0) begin
      e = q[0];
      dmem_wdata_delayed = e.wdata;
      if (e.delay > 0) s_ready = ~e.sel;
    end
    @(negedge clk_i);
    if (q.size() > 0) begin
      k = 0;
      while (dmem_stall === 1'b1 && k < 50) begin
        chk("stall_ren", 32'(s_ren), 32'h0);
        chk("stall_err", 32'(dmem_err), 32'h0);
        chk("stall_wen", 32'(s_wen),
            32'(e.wr ? e.sel : 2'b00));
        k++;
        @(posedge clk_i); #1;
        s_ready = (e.delay > k) ? ~e.sel : 2'b11;
        @(negedge clk_i);
      end
      chk("stalls", 32'(k), 32'(e.stalls));
      chk("err", 32'(dmem_err), 32'(e.err));
      chk("rdata", dmem_rdata, e.rdata);
      chk("wen", 32'(s_wen),
          32'((e.wr && !e.err) ? e.sel : 2'b00));
      if (e.wr && !e.err) begin
        chk("wstrb", 32'(s_wstrb), 32'(e.strb));
        chk("waddr", 32'(s_waddr), 32'(e.waddr));
        chk("wdata", s_wdata, e.wdata);
      end
      void'(q.pop_front());
    end else begin
      chk("idle_stall", 32'(dmem_stall), 32'h0);
      chk("idle_err", 32'(dmem_err), 32'h0);
      chk("idle_rdata", dmem_rdata, 32'h0);
    end
    if (en) begin
      n = model(wen, size, a, wd, delay);
      chk("ren", 32'(s_ren), 32'(n.ren));
      if (n.ren != 2'b00)
        chk("raddr", 32'(s_raddr), 32'(a[15:2]));
      q.push_back(n);
    end else begin
      chk("ren_off", 32'(s_ren), 32'h0);
    end
  endtask

  initial begin
    lat0 = 32'h0;
    lat1 = 32'h0;
    reset = 1'b1;
    dmem_en = 1'b1;
    dmem_wen = 1'b0;
    dmem_size = 3'd2;
    dmem_addr = 32'h0010_0008;
    dmem_wdata_delayed = 32'h0;
    s_ready = 2'b11;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_ren", 32'(s_ren), 32'h0);
    chk("rst_stall", 32'(dmem_stall), 32'h0);
    chk("rst_err", 32'(dmem_err), 32'h0);
    chk("rst_rdata", dmem_rdata, 32'h0);
    chk("rst_wen", 32'(s_wen), 32'h0);
    chk("rst_wstrb", 32'(s_wstrb), 32'h0);
    chk("rst_waddr", 32'(s_waddr), 32'h0);
    reset = 1'b0;
    dmem_en = 1'b0;

    step(1, 0, 3'd2, 32'h0010_0008, 32'h0, 0);
    step(1, 1, 3'd0, 32'h0010_0003, 32'hAB00_0000, 0);
    step(1, 1, 3'd1, 32'h2000_0006, 32'hBEEF_0000, 0);
    step(1, 0, 3'd2, 32'h2000_0010, 32'h0, 3);
    step(1, 0, 3'd2, 32'h0010_0004, 32'h0, 0);
    step(1, 0, 3'd2, 32'h3000_0000, 32'h0, 0);
    step(1, 0, 3'd2, 32'h0010_0002, 32'h0, 0);
    step(1, 1, 3'd2, 32'h0010_0010, 32'h1234_5678, 100);
    step(0, 0, 3'd2, 32'h0, 32'h0, 0);
    step(1, 0, 3'd0, 32'h2000_0001, 32'h0, 1);
    step(1, 1, 3'd2, 32'h0010_0020, 32'hCAFE_F00D, 0);
    step(1, 0, 3'd2, 32'h0010_0020, 32'h0, 0);
    step(1, 1, 3'd1, 32'h2000_0001, 32'h0, 0);
    step(1, 0, 3'd1, 32'h0010_0012, 32'h0, 4);
    step(0, 0, 3'd2, 32'h0, 32'h0, 0);

    // reset lands on a write that the slave is stalling
    step(1, 1, 3'd2, 32'h0010_0040, 32'h0, 100);
    @(posedge clk_i); #1;
    dmem_en = 1'b0;
    dmem_wdata_delayed = 32'h5555_AAAA;
    s_ready = 2'b00;
    @(negedge clk_i);
    chk("pre_rst_stall", 32'(dmem_stall), 32'h1);
    chk("pre_rst_wen", 32'(s_wen), 32'h1);
    @(posedge clk_i); #1;
    reset = 1'b1;
    dmem_en = 1'b1;
    dmem_wen = 1'b0;
    dmem_addr = 32'h0010_0008;
    @(negedge clk_i);
    chk("mid_rst_ren", 32'(s_ren), 32'h0);
    @(posedge clk_i); #1;
    reset = 1'b0;
    dmem_en = 1'b0;
    s_ready = 2'b11;
    @(negedge clk_i);
    chk("post_rst_stall", 32'(dmem_stall), 32'h0);
    chk("post_rst_err", 32'(dmem_err), 32'h0);
    chk("post_rst_wen", 32'(s_wen), 32'h0);
    chk("post_rst_wstrb", 32'(s_wstrb), 32'h0);
    chk("post_rst_waddr", 32'(s_waddr), 32'h0);
    chk("post_rst_rdata", dmem_rdata, 32'h0);
    q.delete();
    step(1, 0, 3'd2, 32'h0010_000C, 32'h0, 0);
    step(0, 0, 3'd2, 32'h0, 32'h0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
